sar_adc_controller: RTL and testbench
=====================================

// Module: sar_adc_controller
// PURPOSE
//  Successive-approximation controller for the discrete ADC. Consumes the debounced comparator
//  output (comparator_db) and drives the external DAC code (R-2R ladder) one trial bit at a time.
//  After each trial code it waits a settle window, samples the comparator, then keeps or clears
//  the bit. Delivers a WIDTH-bit result with a one-cycle done pulse.
// PARAMETERS
//  WIDTH          8   conversion resolution in bits, and DAC code width (>=2)
//  SETTLE_CYCLES  16  clk cycles between a dac_code change and the comparator sample (>=4).
//                     Must cover analog settling plus the 3-cycle debounce latency.
// PORTS
//  clk            in   1      system clock, rising edge
//  reset_n        in   1      asynchronous, active-low reset
//  start          in   1      request a conversion; sampled only in IDLE
//  comparator_db  in   1      debounced comparator: 1 = Vin >= Vdac(dac_code)
//  dac_code       out  WIDTH  code driven to the external DAC
//  busy           out  1      1 whenever the state is not IDLE
//  done           out  1      1-cycle pulse; result is valid in the same cycle
//  result         out  WIDTH  last completed conversion; held until the next done
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - State goes to IDLE immediately.
//   - dac_code=0, result=0, busy=0, done=0, bit index=WIDTH-1, settle counter=0.
//   - A reset mid-conversion abandons the conversion. No done pulse is produced and result reads 0.
//  States: IDLE, SETTLE, DECIDE, DONE
//   - IDLE
//     - If start=1 at a clock edge: dac_code <= 1<<(WIDTH-1), idx <= WIDTH-1, counter <= 0,
//       then go to SETTLE.
//     - Otherwise stay in IDLE; dac_code holds its previous value.
//   - SETTLE
//     - counter increments each cycle.
//     - Leave for DECIDE on the cycle where counter == SETTLE_CYCLES-1,
//       so SETTLE lasts exactly SETTLE_CYCLES cycles.
//     - comparator_db is ignored in this state.
//   - DECIDE (1 cycle)
//     - Sample comparator_db. If 0, clear dac_code[idx]; if 1, keep it.
//     - If idx==0: register the decided code into result and go to DONE.
//     - Else: set dac_code[idx-1], idx <= idx-1, counter <= 0, go to SETTLE.
//   - DONE (1 cycle)
//     - done=1, busy=1. Go to IDLE unconditionally.
//     - dac_code keeps the final result until the next start.
//  Timing
//   - Edge E samples start. done is high during cycle E + WIDTH*(SETTLE_CYCLES+1) + 1.
//     With defaults that is 137 cycles after the start edge.
//   - Minimum start-to-start spacing is WIDTH*(SETTLE_CYCLES+1) + 2 cycles.
//  Handshake
//   - start is level-sensitive in IDLE only; it is ignored in SETTLE, DECIDE and DONE (no queuing).
//   - If start is held high, conversions run back-to-back and IDLE lasts exactly 1 cycle.
//  Arithmetic
//   - The code is unsigned binary. All trial and result values lie in 0 .. 2^WIDTH-1.
//   - An equality input (comparator reads 1) keeps the bit, so Vin == code k converts to k.
//  Registers: done, busy, dac_code and result are all registered outputs with no combinational paths.
// TESTING  (WIDTH=8, SETTLE_CYCLES=16)
//  Bench model: comparator_db = (VIN >= dac_code), delayed by 3 clk.
//  1. VIN=0xA5, single start pulse
//     -> dac_code trials 80,C0,A0,B0,A8,A4,A6,A5.
//     -> done at E+137, result=0xA5, busy low one cycle later.
//  2. VIN=0x00, then VIN=0xFF
//     -> result=0x00 and 0xFF respectively.
//     -> no overflow or wrap; dac_code never exceeds 0xFF.
//  3. start held high for 3 conversions, VIN=0x3C
//     -> done pulses spaced exactly 138 cycles apart, each with result=0x3C.
//     -> extra start pulses during busy produce no extra conversion.
//  4. reset_n=0 asserted 50 cycles into a conversion, VIN=0x77
//     -> outputs go to 0 without waiting for a clock edge; no done pulse.
//     -> after release, a new start gives result=0x77.
//  5. Comparator model forced to the wrong value during the first 12 SETTLE cycles of every bit
//     -> result still correct (0x5A for VIN=0x5A): the comparator is sampled only in DECIDE.

Source files
------------

// File: rtl/sar_adc_controller.sv
// Successive-approximation ADC controller driving an R-2R DAC code
// one trial bit at a time against a debounced comparator.
module sar_adc_controller #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             comparator_db,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_code;
  logic [WIDTH-1:0] w_code_nxt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_nxt;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_idx    <= IW'(WIDTH-1);
      r_cnt    <= '0;
      r_code   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_code   <= w_code_nxt;
      r_result <= w_result_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_code_nxt   = r_code;
    w_result_nxt = r_result;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_code_nxt            = '0;
          w_code_nxt[WIDTH-1]   = 1'b1;
          w_idx_nxt             = IW'(WIDTH-1);
          w_cnt_nxt             = '0;
          w_state_nxt           = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == CW'(SETTLE_CYCLES-1)) begin
          w_state_nxt = S_DECIDE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DECIDE: begin
        // Comparator high means Vin >= trial: the trial bit survives.
        w_code_nxt[r_idx] = comparator_db;
        if (r_idx == '0) begin
          w_result_nxt = w_code_nxt;
          w_state_nxt  = S_DONE;
        end else begin
          w_code_nxt[r_idx - 1'b1] = 1'b1;
          w_idx_nxt                = r_idx - 1'b1;
          w_cnt_nxt                = '0;
          w_state_nxt              = S_SETTLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign dac_code = r_code;
  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;

endmodule

// File: tb/tb_sar_adc_controller.sv
// Bench for sar_adc_controller: ideal comparator with 3-clock lag,
// vector table, random inputs, back-to-back, reset and noise cases.
module tb_sar_adc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       comparator_db;
  logic [7:0] dac_code;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;

  logic [7:0] vin = 8'h00;
  bit         force_wrong = 1'b0;
  logic [2:0] pipe = 3'b000;
  logic [7:0] last_code = 8'h00;
  int         age = 0;

  sar_adc_controller #(.WIDTH(8), .SETTLE_CYCLES(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .comparator_db(comparator_db),
    .dac_code     (dac_code),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  always #5 clk = ~clk;

  // Ideal comparator with lag; optionally lies early in each settle window.
  always @(negedge clk) begin
    if (dac_code != last_code) age = 0;
    else age = age + 1;
    last_code = dac_code;
    pipe = {pipe[1:0], (vin >= dac_code)};
    comparator_db = (force_wrong && age < 12) ? ~pipe[2] : pipe[2];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Binary search reference: trial code shown for bit position b (0 = MSB).
  function automatic int trial_at(input int v, input int b);
    int code = 0;
    for (int k = 7; k > 7 - b; k--) begin
      if (v >= (code | (1 << k))) code = code | (1 << k);
    end
    return code | (1 << (7 - b));
  endfunction

  function automatic int ref_result(input int v);
    int code = 0;
    for (int k = 7; k >= 0; k--) begin
      if (v >= (code | (1 << k))) code = code | (1 << k);
    end
    return code;
  endfunction

  task automatic run_conv(input logic [7:0] v, input logic [7:0] exp,
                          input bit noise, input string nm);
    int ndone = 0;
    vin = v;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n <= 140; n++) begin
      @(negedge clk);
      if (noise && n < 120) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      if (done) ndone++;
      if ((n % 17) == 0 && (n / 17) < 8)
        chk({nm, " trial"}, int'(dac_code), trial_at(int'(v), n / 17));
      if (n == 135) chk({nm, " done early"}, int'(done), 0);
      if (n == 136) begin
        chk({nm, " done"}, int'(done), 1);
        chk({nm, " busy@done"}, int'(busy), 1);
        chk({nm, " result"}, int'(result), int'(exp));
      end
      if (n == 137) begin
        chk({nm, " busy after"}, int'(busy), 0);
        chk({nm, " code hold"}, int'(dac_code), int'(exp));
      end
      if (n == 140) chk({nm, " idle"}, int'(busy), 0);
    end
    chk({nm, " done count"}, ndone, 1);
  endtask

  typedef struct {
    logic [7:0] vin;
    logic [7:0] exp;
    bit         noise;
    bit         fw;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int t_done[$];
    int r_done[$];
    int ncyc;
    logic [7:0] rv;

    tbl[0] = '{8'hA5, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{8'h3C, 8'h3C, 1'b1, 1'b0};
    tbl[4] = '{8'h5A, 8'h5A, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 8'h80, 1'b1, 1'b0};
    tbl[6] = '{8'h7F, 8'h7F, 1'b0, 1'b1};
    tbl[7] = '{8'h01, 8'h01, 1'b1, 1'b0};

    reset_n = 1'b0;
    start   = 1'b0;
    #23;
    chk("reset code", int'(dac_code), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset result", int'(result), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle busy", int'(busy), 0);

    for (int i = 0; i < 8; i++) begin
      force_wrong = tbl[i].fw;
      run_conv(tbl[i].vin, tbl[i].exp, tbl[i].noise, $sformatf("vec%0d", i));
    end
    force_wrong = 1'b0;

    for (int i = 0; i < 6; i++) begin
      rv = 8'($urandom);
      run_conv(rv, 8'(ref_result(int'(rv))), 1'($urandom_range(0, 1)),
               $sformatf("rnd%0d", i));
    end

    // Start held high: conversions run back to back.
    vin = 8'h3C;
    repeat (4) @(negedge clk);
    start = 1'b1;
    ncyc  = 0;
    while (t_done.size() < 3 && ncyc < 600) begin
      @(negedge clk);
      ncyc++;
      if (done) begin
        t_done.push_back(ncyc);
        r_done.push_back(int'(result));
        if (t_done.size() == 3) start = 1'b0;
      end
    end
    chk("b2b count", t_done.size(), 3);
    if (t_done.size() == 3) begin
      chk("b2b gap1", t_done[1] - t_done[0], 138);
      chk("b2b gap2", t_done[2] - t_done[1], 138);
      for (int i = 0; i < 3; i++) chk("b2b result", r_done[i], 'h3C);
    end
    repeat (3) @(negedge clk);
    chk("b2b idle", int'(busy), 0);

    // Asynchronous reset in the middle of a conversion.
    vin = 8'h77;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst code", int'(dac_code), 0);
    chk("arst busy", int'(busy), 0);
    chk("arst result", int'(result), 0);
    chk("arst done", int'(done), 0);
    ncyc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) ncyc++;
    end
    chk("arst quiet", ncyc, 0);
    reset_n = 1'b1;
    ncyc = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done) ncyc++;
    end
    chk("arst no done", ncyc, 0);
    run_conv(8'h77, 8'h77, 1'b0, "post rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
